// File: rtl/trace_state_loader.sv
// Deserializes a ten-word x86 architectural-state frame into parallel register words.
// The shadow fills with the next frame while the committed bundle is held stable downstream.
module trace_state_loader #(
    parameter int NUM_REGS = 10,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_word_valid,
    input  logic [31:0]      i_word,
    input  logic             i_last,
    output logic             o_word_ready,
    output logic [31:0]      o_eax,
    output logic [31:0]      o_ebx,
    output logic [31:0]      o_ecx,
    output logic [31:0]      o_edx,
    output logic [31:0]      o_esi,
    output logic [31:0]      o_edi,
    output logic [31:0]      o_esp,
    output logic [31:0]      o_ebp,
    output logic [31:0]      o_eip,
    output logic [31:0]      o_eflags,
    output logic             o_state_valid,
    input  logic             i_state_ready,
    output logic             o_frame_err,
    output logic [CNT_W-1:0] o_frame_count
);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  idx;
    logic [3:0]  idx_next;
    logic [31:0] shadow [0:NUM_REGS-2];

    logic word_fire;
    logic bundle_fire;
    logic shadow_we;
    logic commit;
    logic err_next;

    assign word_fire   = i_word_valid & o_word_ready;
    assign bundle_fire = o_state_valid & i_state_ready;

    // The final word is written straight to o_eflags, so it may only be taken
    // once the held bundle is either empty or leaving this cycle.
    always_comb begin
        o_word_ready = 1'b0;
        if (!rst) begin
            case (state)
                DRAIN:   o_word_ready = 1'b1;
                FILL:    o_word_ready = (idx != LAST_IDX) | !o_state_valid | i_state_ready;
                default: o_word_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        shadow_we  = 1'b0;
        commit     = 1'b0;
        err_next   = 1'b0;
        if (word_fire) begin
            case (state)
                FILL: begin
                    if (idx == LAST_IDX) begin
                        idx_next = '0;
                        if (i_last) begin
                            commit = 1'b1;
                        end else begin
                            err_next   = 1'b1;
                            state_next = DRAIN;
                        end
                    end else if (i_last) begin
                        err_next = 1'b1;
                        idx_next = '0;
                    end else begin
                        shadow_we = 1'b1;
                        idx_next  = idx + 4'd1;
                    end
                end
                DRAIN: begin
                    if (i_last) begin
                        state_next = FILL;
                        idx_next   = '0;
                    end
                end
                default: begin
                    state_next = FILL;
                    idx_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Stale shadow contents are harmless: idx restarts at 0 after reset or error.
    always_ff @(posedge clk) begin
        if (shadow_we) begin
            shadow[idx] <= i_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_eax         <= '0;
            o_ebx         <= '0;
            o_ecx         <= '0;
            o_edx         <= '0;
            o_esi         <= '0;
            o_edi         <= '0;
            o_esp         <= '0;
            o_ebp         <= '0;
            o_eip         <= '0;
            o_eflags      <= '0;
            o_state_valid <= 1'b0;
            o_frame_err   <= 1'b0;
            o_frame_count <= '0;
        end else begin
            o_frame_err <= err_next;
            if (bundle_fire) begin
                o_frame_count <= o_frame_count + CNT_W'(1);
            end
            if (commit) begin
                o_eax         <= shadow[0];
                o_ebx         <= shadow[1];
                o_ecx         <= shadow[2];
                o_edx         <= shadow[3];
                o_esi         <= shadow[4];
                o_edi         <= shadow[5];
                o_esp         <= shadow[6];
                o_ebp         <= shadow[7];
                o_eip         <= shadow[8];
                o_eflags      <= i_word;
                o_state_valid <= 1'b1;
            end else if (bundle_fire) begin
                o_state_valid <= 1'b0;
            end
        end
    end

endmodule
